// File: rtl/bn_fmap_streamer.sv
// rtl/bn_fmap_streamer.sv - streams a normalized feature map out of BRAM as channel-framed stream beats
module bn_fmap_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 128,
    parameter int HEIGHT     = 7,
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 13,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    output logic                  m_tuser
);
    localparam int PIX   = HEIGHT * WIDTH;
    localparam int DEPTH = RD_LATENCY + 1;
    localparam int PIXW  = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int EW    = DATA_WIDTH + 2;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                state;
    logic [PIXW-1:0]       pix_cnt;
    logic [CHW-1:0]        ch_cnt;
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [RD_LATENCY-1:0] last_pipe;
    logic [RD_LATENCY-1:0] user_pipe;
    logic [EW-1:0]         fifo_mem [0:3];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            fifo_cnt;
    logic [2:0]            pipe_cnt;
    logic [EW-1:0]         head;
    logic                  push;
    logic                  pop;
    logic                  issue_last;
    logic                  issue_user;

    assign issue_last = (pix_cnt == PIXW'(PIX - 1));
    assign issue_user = issue_last && (ch_cnt == CHW'(CHANNELS - 1));
    assign push       = vld_pipe[RD_LATENCY-1];
    assign pop        = m_tvalid && m_tready;
    assign head       = fifo_mem[rd_ptr];

    assign m_tvalid = (fifo_cnt != 3'd0);
    assign m_tdata  = m_tvalid ? head[DATA_WIDTH-1:0] : '0;
    assign m_tlast  = m_tvalid & head[DATA_WIDTH];
    assign m_tuser  = m_tvalid & head[DATA_WIDTH+1];

    always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_cnt = pipe_cnt + {2'b00, vld_pipe[i]};
        end
    end

    // A pop in this cycle frees a slot, so a read may be issued against it without ever overflowing.
    assign bram_en = (state == S_READ) &&
                     (({1'b0, fifo_cnt} + {1'b0, pipe_cnt}) < (4'(DEPTH) + {3'b000, pop}));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {user_pipe[RD_LATENCY-1], last_pipe[RD_LATENCY-1], bram_dout};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bram_addr <= '0;
            pix_cnt   <= '0;
            ch_cnt    <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            user_pipe <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            done <= 1'b0;

            // Flags travel with each read so they stay attached to their data word.
            vld_pipe[0]  <= bram_en;
            last_pipe[0] <= bram_en && issue_last;
            user_pipe[0] <= bram_en && issue_user;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                user_pipe[i] <= user_pipe[i-1];
            end

            if (push) wr_ptr <= (wr_ptr == 2'(DEPTH - 1)) ? 2'd0 : wr_ptr + 2'd1;
            if (pop)  rd_ptr <= (rd_ptr == 2'(DEPTH - 1)) ? 2'd0 : rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (bram_en) begin
                if (issue_last) begin
                    pix_cnt <= '0;
                    ch_cnt  <= issue_user ? '0 : ch_cnt + CHW'(1);
                end else begin
                    pix_cnt <= pix_cnt + PIXW'(1);
                end
                bram_addr <= issue_user ? '0 : bram_addr + ADDR_WIDTH'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_READ;
                        busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (bram_en && issue_user) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if ((pipe_cnt == 3'd0) &&
                        ((fifo_cnt == 3'd0) || ((fifo_cnt == 3'd1) && pop))) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bn_fmap_streamer.sv
// tb/tb_bn_fmap_streamer.sv - randomized and directed checks of bn_fmap_streamer at read latencies 1 and 2
module tb_bn_fmap_streamer;
    localparam int PIX   = 4;
    localparam int TOTAL = 8;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        start [2];
    logic        busy_s [2];
    logic        done_s [2];
    logic        en_s [2];
    logic [12:0] addr_s [2];
    logic [7:0]  dout_s [2];
    logic        tvalid_s [2];
    logic        tready [2];
    logic [7:0]  tdata_s [2];
    logic        tlast_s [2];
    logic        tuser_s [2];
    logic [7:0]  d1 [2];
    logic [7:0]  d2 [2];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int mode [2];
    int start_cyc [2];

    bit in_frame [2];
    bit pend_done [2];
    bit prev_stall [2];
    logic [9:0] prev_beat [2];
    int issued [2];
    int beats [2];
    int fcyc [2];
    int frames [2];
    int nlast [2];
    int nuser [2];
    int first_off [2];
    int last_off [2];
    int first_dat [2];
    int last_dat [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bn_fmap_streamer #(.DATA_WIDTH(8), .CHANNELS(2), .HEIGHT(2), .WIDTH(2), .ADDR_WIDTH(13), .RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .busy(busy_s[0]), .done(done_s[0]),
        .bram_en(en_s[0]), .bram_addr(addr_s[0]), .bram_dout(dout_s[0]),
        .m_tvalid(tvalid_s[0]), .m_tready(tready[0]), .m_tdata(tdata_s[0]),
        .m_tlast(tlast_s[0]), .m_tuser(tuser_s[0])
    );

    bn_fmap_streamer #(.DATA_WIDTH(8), .CHANNELS(2), .HEIGHT(2), .WIDTH(2), .ADDR_WIDTH(13), .RD_LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .busy(busy_s[1]), .done(done_s[1]),
        .bram_en(en_s[1]), .bram_addr(addr_s[1]), .bram_dout(dout_s[1]),
        .m_tvalid(tvalid_s[1]), .m_tready(tready[1]), .m_tdata(tdata_s[1]),
        .m_tlast(tlast_s[1]), .m_tuser(tuser_s[1])
    );

    // BRAM holds mem[a] = a-3; idle reads return a marker value that never appears in a frame.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            d1[i] <= en_s[i] ? 8'(addr_s[i] - 13'd3) : 8'h5A;
            d2[i] <= d1[i];
        end
    end
    assign dout_s[0] = d1[0];
    assign dout_s[1] = d2[1];

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            case (mode[i])
                0:       tready[i] = 1'b1;
                1:       tready[i] = ((cyc - start_cyc[i]) % 4 == 0) || ((cyc - start_cyc[i]) % 4 == 3);
                2:       tready[i] = (cyc - start_cyc[i]) >= 21;
                default: tready[i] = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] outs(input int i);
        return {5'd0, busy_s[i], done_s[i], en_s[i], tvalid_s[i], tlast_s[i], tuser_s[i], tdata_s[i], addr_s[i]};
    endfunction

    always @(negedge clk) begin
        bit acc;
        bit exp_done;
        int lat;
        logic signed [7:0] sd;
        for (int i = 0; i < 2; i++) begin
            lat = i + 1;
            if (!rst_n[i]) begin
                chk(outs(i) == 32'd0, "reset_outputs", outs(i), 0);
                in_frame[i] = 0; pend_done[i] = 0; prev_stall[i] = 0;
                issued[i] = 0; beats[i] = 0; fcyc[i] = 0;
            end else begin
                if (in_frame[i]) fcyc[i]++;
                exp_done = pend_done[i];
                chk(busy_s[i] == in_frame[i], "busy", busy_s[i], in_frame[i]);
                chk(done_s[i] == exp_done, "done", done_s[i], exp_done);
                if (!in_frame[i]) chk(!en_s[i] && !tvalid_s[i], "idle_quiet", {en_s[i], tvalid_s[i]}, 0);
                if (in_frame[i] && fcyc[i] == 1) chk(en_s[i], "first_en", en_s[i], 1);
                if (en_s[i]) begin
                    chk(in_frame[i] && issued[i] < TOTAL && addr_s[i] == 13'(issued[i]), "rd_addr", addr_s[i], issued[i]);
                    issued[i]++;
                end
                if (prev_stall[i])
                    chk(tvalid_s[i] && {tlast_s[i], tuser_s[i], tdata_s[i]} == prev_beat[i], "stall_hold",
                        {tvalid_s[i], tlast_s[i], tuser_s[i], tdata_s[i]}, {1'b1, prev_beat[i]});
                if (in_frame[i] && tvalid_s[i] && first_off[i] < 0) first_off[i] = fcyc[i];
                acc = tvalid_s[i] && tready[i];
                if (acc) begin
                    sd = tdata_s[i];
                    chk(in_frame[i] && beats[i] < TOTAL, "beat_in_frame", beats[i], TOTAL - 1);
                    chk(int'(sd) == beats[i] - 3, $sformatf("beat%0d_data", beats[i]), int'(sd), beats[i] - 3);
                    chk(tlast_s[i] == (beats[i] % PIX == PIX - 1), $sformatf("beat%0d_tlast", beats[i]),
                        tlast_s[i], (beats[i] % PIX == PIX - 1));
                    chk(tuser_s[i] == (beats[i] == TOTAL - 1), $sformatf("beat%0d_tuser", beats[i]),
                        tuser_s[i], (beats[i] == TOTAL - 1));
                    if (tlast_s[i]) nlast[i]++;
                    if (tuser_s[i]) nuser[i]++;
                    if (beats[i] == 0) first_dat[i] = int'(sd);
                    if (beats[i] == TOTAL - 1) begin
                        last_dat[i] = int'(sd);
                        last_off[i] = fcyc[i];
                    end
                    beats[i]++;
                end
                if (in_frame[i]) chk(issued[i] - beats[i] <= lat + 1, "outstanding", issued[i] - beats[i], lat + 1);
                prev_stall[i] = tvalid_s[i] && !tready[i];
                prev_beat[i]  = {tlast_s[i], tuser_s[i], tdata_s[i]};
                pend_done[i]  = acc && beats[i] == TOTAL;
                if (exp_done) begin
                    chk(issued[i] == TOTAL && beats[i] == TOTAL, "frame_complete", beats[i], TOTAL);
                    frames[i]++;
                    in_frame[i] = 0;
                end else if (!in_frame[i] && start[i]) begin
                    in_frame[i] = 1; issued[i] = 0; beats[i] = 0; fcyc[i] = 0;
                    first_off[i] = -1; nlast[i] = 0; nuser[i] = 0;
                end
            end
        end
    end

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        start_cyc[i] = cyc;
        @(posedge clk); #1;
        start[i] = 1'b0;
    endtask

    task automatic run_frame(input int i, input int m, input int gap, input bit inj);
        bit seen = 0;
        mode[i] = m;
        repeat (gap) @(posedge clk);
        #1;
        pulse_start(i);
        for (int k = 0; k < 300 && !seen; k++) begin
            if (m == 2 && k == 19) begin
                @(negedge clk); #1;
                chk(issued[i] == i + 2 && !en_s[i], "stall_reads", issued[i], i + 2);
            end
            if (done_s[i]) begin
                seen = 1;
            end else begin
                if (inj && k == 2) start[i] = 1'b1;
                if (inj && k == 3) start[i] = 1'b0;
                @(posedge clk); #1;
            end
        end
        chk(seen, "frame_timeout", seen, 1);
        if (inj && seen) begin
            start[i] = 1'b1;
            @(posedge clk); #1;
            start[i] = 1'b0;
        end
    endtask

    task automatic check_literals(input int i);
        chk(first_dat[i] == -3, "first_data", first_dat[i], -3);
        chk(last_dat[i] == 4, "last_data", last_dat[i], 4);
        chk(first_off[i] == i + 3, "first_valid_lat", first_off[i], i + 3);
        chk(last_off[i] == TOTAL + i + 2, "last_beat_lat", last_off[i], TOTAL + i + 2);
        chk(nlast[i] == 2, "tlast_count", nlast[i], 2);
        chk(nuser[i] == 1, "tuser_count", nuser[i], 1);
    endtask

    task automatic reset_mid(input int i);
        mode[i] = 0;
        @(posedge clk); #1;
        pulse_start(i);
        for (int k = 0; k < 100 && beats[i] < 5; k++) begin
            @(posedge clk); #1;
        end
        chk(beats[i] >= 5, "reset_wait", beats[i], 5);
        @(posedge clk); #2;
        rst_n[i] = 1'b0;
        #1;
        chk(outs(i) == 32'd0, "async_reset", outs(i), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n[i] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; tready[i] = 1'b1;
            mode[i] = 0; start_cyc[i] = 0; frames[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_frame(i, 0, 2, 0);
            check_literals(i);
            run_frame(i, 1, 2, 0);
            run_frame(i, 2, 2, 0);
            run_frame(i, 0, 2, 1);
            reset_mid(i);
            run_frame(i, 0, 1, 0);
            run_frame(i, 0, 3, 0);
            run_frame(i, 0, 2, 0);
            repeat (4) run_frame(i, 3, $urandom_range(1, 4), 0);
            repeat (5) @(posedge clk);
            #1;
            chk(frames[i] == 11, "frame_count", frames[i], 11);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bn_fmap_streamer.md
BN_FMAP_STREAMER -- requirements
Module: bn_fmap_streamer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DATA_WIDTH, 8: signed normalized sample width.
- CHANNELS, 128: feature-map channels.
- HEIGHT, 7: rows per channel.
- WIDTH, 8: columns per channel.
- ADDR_WIDTH, 13: output-BRAM address width.
- RD_LATENCY, 1: BRAM read latency in cycles; legal values are 1 and 2.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle pulse that begins a frame readout.
- busy, out, 1: high from the start acceptance until the done pulse, inclusive.
- done, out, 1: one-cycle pulse after the last beat is accepted.
- bram_en, out, 1: read enable to the normalized-output BRAM.
- bram_addr, out, ADDR_WIDTH: read address.
- bram_dout, in, DATA_WIDTH: read data, valid RD_LATENCY cycles after bram_en.
- m_tvalid, out, 1: stream data valid.
- m_tready, in, 1: stream sink ready.
- m_tdata, out, DATA_WIDTH: sample, passed through bit-exact.
- m_tlast, out, 1: marks the last pixel of a channel.
- m_tuser, out, 1: marks the last pixel of the frame.

Function
REQ-003 Derived constants: PIX = HEIGHT*WIDTH and TOTAL = CHANNELS*PIX; TOTAL SHALL be at most 2^ADDR_WIDTH.
REQ-004 FSM states SHALL be IDLE, READ, DRAIN and DONE.
REQ-005 State transitions SHALL be:
- IDLE to READ on start.
- READ to DRAIN in the cycle after the read of address TOTAL-1 is issued.
- DRAIN to DONE when the buffer is empty and no read is in flight.
- DONE to IDLE unconditionally after one cycle.
REQ-006 start SHALL be ignored in every state except IDLE.
REQ-007 Reads SHALL be issued in channel-major, row-major order; bram_addr = ch*PIX + pix, increasing by 1 per issued read from 0 to TOTAL-1.
REQ-008 Each read is a cycle with bram_en=1; bram_en SHALL be 0 outside READ.
REQ-009 Returned data SHALL enter an internal FIFO of depth RD_LATENCY+1.
REQ-010 A read SHALL be issued only when (FIFO occupancy + reads in flight) < RD_LATENCY+1, so the FIFO never overflows and no returned word is lost.
REQ-011 m_tvalid SHALL equal FIFO not-empty, and m_tdata SHALL be the FIFO head.
REQ-012 A beat transfers when m_tvalid and m_tready are both 1.
REQ-013 While m_tvalid=1 and m_tready=0, m_tdata, m_tlast and m_tuser SHALL hold stable.
REQ-014 m_tlast SHALL be 1 exactly on beats with pixel index PIX-1 of each channel, i.e. CHANNELS times per frame.
REQ-015 m_tuser SHALL be 1 only on beat TOTAL-1, which also carries m_tlast=1.
REQ-016 Sideband flags SHALL be stored in the FIFO alongside the data; they SHALL NOT be derived from the read counter.
REQ-017 The first bram_en SHALL occur in the cycle after start is sampled.
REQ-018 The first m_tvalid SHALL occur RD_LATENCY+1 cycles after that first bram_en.
REQ-019 With m_tready held at 1, the block SHALL sustain one beat per cycle, and the last beat SHALL occur TOTAL+RD_LATENCY+1 cycles after start.
REQ-020 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-021 Pixel and channel counters SHALL wrap pixel PIX-1 to 0 with channel +1; channel CHANNELS-1 with pixel PIX-1 ends issue.
REQ-022 done SHALL pulse for exactly one cycle, in the DONE state.
REQ-023 busy SHALL fall in the cycle after done.
REQ-024 A start coincident with the done cycle SHALL be ignored.

Reset
REQ-025 While rst_n=0, the following outputs SHALL be 0: busy, done, bram_en, bram_addr, m_tvalid, m_tdata, m_tlast and m_tuser.
REQ-026 While rst_n=0, the FSM SHALL be in IDLE, counters SHALL be 0 and the FIFO SHALL be empty.
REQ-027 Reset asserted mid-frame SHALL abandon the frame, discarding in-flight reads.
REQ-028 The first start after reset release SHALL begin at address 0.

Verification
REQ-029 Test configuration: CHANNELS=2, HEIGHT=2, WIDTH=2, and both RD_LATENCY=1 and RD_LATENCY=2. The BRAM model returns mem[a]=a-3.
REQ-030 The bench SHALL cover these directed scenarios:
- m_tready=1, pulse start: 8 beats with data -3..4 on consecutive cycles; m_tlast on beats 3 and 7; m_tuser on beat 7 only; then one done pulse; no further bram_en.
- m_tready toggles 1,0,0,1 repeating: identical 8-beat data sequence with no loss or duplication; data and flags stable during stalls; FIFO occupancy never exceeds RD_LATENCY+1.
- m_tready=0 for 20 cycles after start: exactly RD_LATENCY+1 reads issued, then bram_en=0; raising m_tready completes the frame correctly.
- start pulsed again during READ and on the done cycle: both ignored; addresses and beat count are unchanged (8 beats, one done).
- rst_n pulled low after beat 4: all outputs 0 asynchronously; after release, a new start yields the full 8-beat frame from address 0.
- Two back-to-back frames (start two cycles after done): each frame gives 8 beats and one done; the second frame begins at address 0.
